// File: rtl/axi_write_arbiter.sv
// AXI-Lite write arbiter: N requesters share one AW/W/B master port.
// Port-0 priority or round-robin grant, with optional response timeout.
module axi_write_arbiter #(
    parameter int N_REQ       = 2,
    parameter bit PRIO_PORT0  = 1'b1,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*32-1:0] addr_i,
    input  logic [N_REQ*32-1:0] data_i,
    input  logic [N_REQ*4-1:0]  strb_i,
    output logic [N_REQ-1:0]    ack_o,
    output logic [N_REQ-1:0]    done_o,
    output logic [N_REQ-1:0]    err_o,
    output logic                busy_o,
    output logic [31:0]         aw_addr_o,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic [31:0]         w_data_o,
    output logic [3:0]          w_strb_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    input  logic [1:0]          b_resp_i,
    input  logic                b_valid_i,
    output logic                b_ready_o
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYC > 0);
    localparam logic [CW-1:0] CNT_MAX = CW'(TMO_EN ? TIMEOUT_CYC : 0);
    localparam logic [CW-1:0] CNT_HIT = CW'(TMO_EN ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] pick;
    logic          pick_valid;
    logic [CW-1:0] cnt;
    logic          b_fire;
    logic          tmo;

    function automatic logic [GW-1:0] wrap(input int v);
        return GW'((v >= N_REQ) ? v - N_REQ : v);
    endfunction

    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!pick_valid && req_i[wrap(int'(last_grant) + i)]) begin
                pick       = wrap(int'(last_grant) + i);
                pick_valid = 1'b1;
            end
        end
        if (PRIO_PORT0 && req_i[0]) begin
            pick       = '0;
            pick_valid = 1'b1;
        end
    end

    // B is only honoured once both address and data have been accepted
    assign b_fire = (state != IDLE) && b_valid_i && b_ready_o
                    && !aw_valid_o && !w_valid_o;
    assign tmo    = TMO_EN && (state != IDLE) && (cnt == CNT_HIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(N_REQ - 1);
            cnt        <= '0;
            ack_o      <= '0;
            done_o     <= '0;
            err_o      <= '0;
            busy_o     <= 1'b0;
            aw_addr_o  <= '0;
            aw_valid_o <= 1'b0;
            w_data_o   <= '0;
            w_strb_o   <= 4'hF;
            w_valid_o  <= 1'b0;
            b_ready_o  <= 1'b0;
        end else begin
            ack_o  <= '0;
            done_o <= '0;
            err_o  <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant       <= pick;
                        aw_addr_o   <= addr_i[int'(pick)*32 +: 32];
                        w_data_o    <= data_i[int'(pick)*32 +: 32];
                        w_strb_o    <= strb_i[int'(pick)*4 +: 4];
                        ack_o[pick] <= 1'b1;
                        aw_valid_o  <= 1'b1;
                        w_valid_o   <= 1'b1;
                        b_ready_o   <= 1'b1;
                        busy_o      <= 1'b1;
                        cnt         <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE, RESP: begin
                    if (aw_valid_o && aw_ready_i) aw_valid_o <= 1'b0;
                    if (w_valid_o && w_ready_i) w_valid_o <= 1'b0;
                    if (state == ISSUE
                        && (!aw_valid_o || aw_ready_i)
                        && (!w_valid_o || w_ready_i))
                        state <= RESP;
                    if (TMO_EN && cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    // completion overrides the handshake updates above
                    if (b_fire || tmo) begin
                        done_o[grant] <= 1'b1;
                        err_o[grant]  <= b_fire ? (b_resp_i != 2'b00) : 1'b1;
                        aw_valid_o    <= 1'b0;
                        w_valid_o     <= 1'b0;
                        b_ready_o     <= 1'b0;
                        busy_o        <= 1'b0;
                        last_grant    <= grant;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: directed scenarios with literal checks,
// then random traffic checked every cycle against a transaction model.
`timescale 1ns/1ps
module tb_axi_write_arbiter;
    localparam int N    = 4;
    localparam bit PRIO = 1'b1;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N*32-1:0] addr_i = '0;
    logic [N*32-1:0] data_i = '0;
    logic [N*4-1:0]  strb_i = '0;
    logic [N-1:0]    ack_o, done_o, err_o;
    logic            busy_o;
    logic [31:0]     aw_addr_o;
    logic            aw_valid_o;
    logic            aw_ready_i = 1'b0;
    logic [31:0]     w_data_o;
    logic [3:0]      w_strb_o;
    logic            w_valid_o;
    logic            w_ready_i = 1'b0;
    logic [1:0]      b_resp_i = 2'b00;
    logic            b_valid_i = 1'b0;
    logic            b_ready_o;

    axi_write_arbiter #(
        .N_REQ(N), .PRIO_PORT0(PRIO), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i),
        .data_i(data_i), .strb_i(strb_i), .ack_o(ack_o),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
        .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o),
        .aw_ready_i(aw_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_valid_o(w_valid_o),
        .w_ready_i(w_ready_i), .b_resp_i(b_resp_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // transaction-level model: who owns the bus, what is still pending
    bit           m_act;
    int           m_cur, m_last, m_age;
    logic [N-1:0] e_ack, e_done, e_err;
    logic         e_busy, e_awv, e_wv, e_br;
    logic [31:0]  e_addr, e_data;
    logic [3:0]   e_strb;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_act  = 0;
        m_last = N - 1;
        m_cur  = 0;
        m_age  = 0;
        e_ack  = '0;
        e_done = '0;
        e_err  = '0;
        e_busy = 0;
        e_awv  = 0;
        e_wv   = 0;
        e_br   = 0;
    endtask

    task automatic model_step();
        int  g;
        bit  bf;
        e_ack  = '0;
        e_done = '0;
        e_err  = '0;
        g      = -1;
        if (!m_act) begin
            if (PRIO && req_i[0]) g = 0;
            else
                for (int k = 1; k <= N; k++)
                    if (g < 0 && req_i[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) begin
                m_act    = 1;
                m_cur    = g;
                m_age    = 0;
                e_ack[g] = 1'b1;
                e_awv    = 1;
                e_wv     = 1;
                e_br     = 1;
                e_busy   = 1;
                e_addr   = addr_i[g*32 +: 32];
                e_data   = data_i[g*32 +: 32];
                e_strb   = strb_i[g*4 +: 4];
            end
        end else begin
            m_age++;
            bf = !e_awv && !e_wv && b_valid_i;
            if (bf || m_age == TMO) begin
                e_done[m_cur] = 1'b1;
                e_err[m_cur]  = bf ? (b_resp_i != 2'b00) : 1'b1;
                m_act  = 0;
                m_last = m_cur;
                e_awv  = 0;
                e_wv   = 0;
                e_br   = 0;
                e_busy = 0;
            end else begin
                if (aw_ready_i) e_awv = 0;
                if (w_ready_i) e_wv = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("ack", 32'(ack_o), 32'(e_ack));
        chk("done", 32'(done_o), 32'(e_done));
        chk("err", 32'(err_o), 32'(e_err));
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("aw_valid", 32'(aw_valid_o), 32'(e_awv));
        chk("w_valid", 32'(w_valid_o), 32'(e_wv));
        chk("b_ready", 32'(b_ready_o), 32'(e_br));
        if (e_awv) chk("aw_addr", aw_addr_o, e_addr);
        if (e_wv) begin
            chk("w_data", w_data_o, e_data);
            chk("w_strb", 32'(w_strb_o), 32'(e_strb));
        end
    endtask

    // one clock: model consumes current inputs, then compare after the edge
    task automatic cycle();
        model_step();
        @(negedge clk);
        check_all();
        req_i = req_i & ~e_ack;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"}, 32'(ack_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_awv"}, 32'(aw_valid_o), 32'd0);
        chk({tag, "_wv"}, 32'(w_valid_o), 32'd0);
        chk({tag, "_brdy"}, 32'(b_ready_o), 32'd0);
        chk({tag, "_addr"}, aw_addr_o, 32'd0);
        chk({tag, "_data"}, w_data_o, 32'd0);
        chk({tag, "_strb"}, 32'(w_strb_o), 32'hF);
    endtask

    task automatic wait_ack(input string nm, input logic [N-1:0] want);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (ack_o == '0 && n < 40);
        chk(nm, 32'(ack_o), 32'(want));
    endtask

    task automatic wait_done(input string nm, input logic [N-1:0] want_d,
                             input logic [N-1:0] want_e, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (done_o == '0 && n < 40);
        chk({nm, "_done"}, 32'(done_o), 32'(want_d));
        chk({nm, "_err"}, 32'(err_o), 32'(want_e));
    endtask

    task automatic set_port(input int k, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        addr_i[k*32 +: 32] = a;
        data_i[k*32 +: 32] = d;
        strb_i[k*4 +: 4]   = s;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int idx;
        int sweep_exp[5];
        sweep_exp = '{0, 1, 2, 3, 0};
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // single write from port 1
        aw_ready_i = 1'b1;
        w_ready_i  = 1'b1;
        b_valid_i  = 1'b1;
        b_resp_i   = 2'b00;
        set_port(1, 32'h40, 32'hDEADBEEF, 4'hF);
        req_i = 4'b0010;
        cycle();
        chk("single_ack", 32'(ack_o), 32'b0010);
        chk("single_addr", aw_addr_o, 32'h40);
        chk("single_data", w_data_o, 32'hDEADBEEF);
        cycle();
        chk("single_awv_drop", 32'(aw_valid_o), 32'd0);
        chk("single_brdy", 32'(b_ready_o), 32'd1);
        cycle();
        chk("single_done", 32'(done_o), 32'b0010);
        chk("single_err", 32'(err_o), 32'd0);
        chk("single_brdy_drop", 32'(b_ready_o), 32'd0);

        // simultaneous requests: port 0 priority, then port 1
        set_port(0, 32'h100, 32'h11111111, 4'h3);
        set_port(1, 32'h200, 32'h22222222, 4'hC);
        req_i = 4'b0011;
        wait_ack("prio_first", 4'b0001);
        wait_ack("prio_second", 4'b0010);
        wait_done("prio_second", 4'b0010, 4'b0000, n);

        // slave error, then a clean write
        b_resp_i = 2'b10;
        set_port(2, 32'h300, 32'h33333333, 4'h5);
        req_i = 4'b0100;
        wait_ack("err_ack", 4'b0100);
        wait_done("slverr", 4'b0100, 4'b0100, n);
        b_resp_i = 2'b00;
        set_port(3, 32'h400, 32'h44444444, 4'hA);
        req_i = 4'b1000;
        wait_ack("after_err_ack", 4'b1000);
        wait_done("after_err", 4'b1000, 4'b0000, n);

        // AW delayed, W immediate
        aw_ready_i = 1'b0;
        req_i = 4'b1000;
        wait_ack("split1_ack", 4'b1000);
        cycle();
        chk("split1_w_drop", 32'(w_valid_o), 32'd0);
        chk("split1_aw_hold", 32'(aw_valid_o), 32'd1);
        cycle();
        cycle();
        aw_ready_i = 1'b1;
        wait_done("split1", 4'b1000, 4'b0000, n);
        chk("split1_lat", 32'(n), 32'd2);

        // W delayed, AW immediate
        w_ready_i = 1'b0;
        req_i = 4'b0010;
        wait_ack("split2_ack", 4'b0010);
        cycle();
        chk("split2_aw_drop", 32'(aw_valid_o), 32'd0);
        chk("split2_w_hold", 32'(w_valid_o), 32'd1);
        cycle();
        cycle();
        w_ready_i = 1'b1;
        wait_done("split2", 4'b0010, 4'b0000, n);

        // no B response: timeout
        b_valid_i = 1'b0;
        req_i = 4'b0001;
        wait_ack("tmo_ack", 4'b0001);
        wait_done("tmo", 4'b0001, 4'b0001, n);
        chk("tmo_cycles", 32'(n), 32'd8);
        chk("tmo_brdy", 32'(b_ready_o), 32'd0);

        // sweep with every port requesting
        b_valid_i = 1'b1;
        req_i = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            if (s == 4) req_i[0] = 1'b1;
            n = 0;
            do begin
                cycle();
                n++;
            end while (ack_o == '0 && n < 40);
            idx = -1;
            for (int k = 0; k < N; k++) if (ack_o[k]) idx = k;
            chk("sweep", 32'(idx), 32'(sweep_exp[s]));
        end
        repeat (4) cycle();

        // reset while AW is outstanding, request held through reset
        aw_ready_i = 1'b0;
        w_ready_i  = 1'b0;
        b_valid_i  = 1'b0;
        set_port(2, 32'h500, 32'h55555555, 4'h9);
        req_i = 4'b0100;
        wait_ack("prerst_ack", 4'b0100);
        req_i[2] = 1'b1;
        cycle();
        chk("prerst_awv", 32'(aw_valid_o), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        aw_ready_i = 1'b1;
        w_ready_i  = 1'b1;
        b_valid_i  = 1'b1;
        cycle();
        chk("rst_regrant", 32'(ack_o), 32'b0100);
        repeat (4) cycle();

        // random traffic in three slave behaviours
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 1000; c++) begin
                aw_ready_i = 1'($urandom_range(0, 1));
                w_ready_i  = 1'($urandom_range(0, 1));
                case (ph)
                    0: b_valid_i = 1'($urandom_range(0, 1));
                    1: b_valid_i = ($urandom_range(0, 19) == 0);
                    default: b_valid_i = ($urandom_range(0, 4) != 0);
                endcase
                b_resp_i = 2'($urandom_range(0, 3));
                for (int k = 0; k < N; k++) begin
                    if (!req_i[k]) begin
                        set_port(k, $urandom(), $urandom(), 4'($urandom()));
                        if ($urandom_range(0, 3) == 0) req_i[k] = 1'b1;
                    end
                end
                cycle();
            end
        end

        req_i     = '0;
        b_valid_i = 1'b1;
        repeat (20) cycle();
        chk("drain_busy", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
